// File: rtl/bolme_birimi_pkg.sv
// Shared definitions for the RV32M divider: operation encodings, FSM states,
// default operand width and small operation-decoding helpers.
`timescale 1ns/1ps
package bolme_birimi_pkg;

  localparam int BOLME_GENISLIK = 32;

  localparam logic [1:0] BOLME_DIV  = 2'b00;
  localparam logic [1:0] BOLME_DIVU = 2'b01;
  localparam logic [1:0] BOLME_REM  = 2'b10;
  localparam logic [1:0] BOLME_REMU = 2'b11;

  typedef enum logic [1:0] {
    BOSTA   = 2'b00,
    HESAPLA = 2'b01,
    BITTI   = 2'b10
  } durum_t;

  // DIV and REM treat their operands as two's-complement numbers
  function automatic logic isaretli_islem(input logic [1:0] islem);
    return ~islem[0];
  endfunction

  // REM and REMU return the remainder instead of the quotient
  function automatic logic kalan_islem(input logic [1:0] islem);
    return islem[1];
  endfunction

endpackage

// File: rtl/bolme_birimi_adimi.sv
// One restoring-division step: shift {kalan,bolum} left, subtract the divisor
// when it fits, and shift the resulting quotient bit in.
`timescale 1ns/1ps
module bolme_adimi #(
  parameter int W = 32
) (
  input  logic [W-1:0] kalan,
  input  logic [W-1:0] bolum,
  input  logic [W-1:0] bolen,
  output logic [W-1:0] kalan_n,
  output logic [W-1:0] bolum_n
);

  logic [W:0] kaydirilmis;
  logic       yeter;

  // The shifted remainder needs W+1 bits, but once the divisor fits the
  // difference is below the divisor, so a W-bit subtraction is exact.
  always_comb begin
    kaydirilmis = {kalan, bolum[W-1]};
    yeter       = (kaydirilmis >= {1'b0, bolen});
    if (yeter) begin
      kalan_n = kaydirilmis[W-1:0] - bolen;
    end else begin
      kalan_n = kaydirilmis[W-1:0];
    end
    bolum_n = {bolum[W-2:0], yeter};
  end

endmodule

// File: rtl/bolme_birimi.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) for the YURUT stage: radix-2
// restoring, one quotient bit per cycle, single-cycle special cases.
`timescale 1ns/1ps
module bolme_birimi
  import bolme_birimi_pkg::*;
#(
  parameter int VERI_BIT = BOLME_GENISLIK
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                basla_i,
  input  logic [1:0]          islem_i,
  input  logic [VERI_BIT-1:0] bolunen_i,
  input  logic [VERI_BIT-1:0] bolen_i,
  input  logic                durdur_i,
  input  logic                iptal_i,
  output logic                hazir_o,
  output logic [VERI_BIT-1:0] sonuc_o
);

  localparam int SW = $clog2(VERI_BIT);
  localparam logic [VERI_BIT-1:0] SIFIR     = {VERI_BIT{1'b0}};
  localparam logic [VERI_BIT-1:0] BIR       = {{(VERI_BIT-1){1'b0}}, 1'b1};
  localparam logic [VERI_BIT-1:0] TUM_BIR   = {VERI_BIT{1'b1}};
  localparam logic [VERI_BIT-1:0] EN_KUCUK  = {1'b1, {(VERI_BIT-1){1'b0}}};
  localparam logic [SW-1:0]       SAYAC_BIR = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0]       SAYAC_SON = SW'(VERI_BIT - 1);

  durum_t              durum;
  logic [SW-1:0]       sayac;
  logic [1:0]          islem;
  logic [VERI_BIT-1:0] kalan;
  logic [VERI_BIT-1:0] bolum;
  logic [VERI_BIT-1:0] bolen;
  logic                bolum_isaret;
  logic                kalan_isaret;

  logic [VERI_BIT-1:0] kalan_n;
  logic [VERI_BIT-1:0] bolum_n;
  logic                isaretli;
  logic                sifir_bolen;
  logic                tasma;
  logic [VERI_BIT-1:0] mutlak_a;
  logic [VERI_BIT-1:0] mutlak_b;
  logic [VERI_BIT-1:0] ozel_sonuc;
  logic [VERI_BIT-1:0] secilen;
  logic                negatif;
  logic [VERI_BIT-1:0] son_deger;

  bolme_adimi #(.W(VERI_BIT)) u_adim (
    .kalan   (kalan),
    .bolum   (bolum),
    .bolen   (bolen),
    .kalan_n (kalan_n),
    .bolum_n (bolum_n)
  );

  // Start-cycle decode: operand magnitudes and the two single-cycle cases
  always_comb begin
    isaretli    = isaretli_islem(islem_i);
    sifir_bolen = (bolen_i == SIFIR);
    tasma       = isaretli && (bolunen_i == EN_KUCUK) && (bolen_i == TUM_BIR);
    if (isaretli && bolunen_i[VERI_BIT-1]) begin
      mutlak_a = ~bolunen_i + BIR;
    end else begin
      mutlak_a = bolunen_i;
    end
    if (isaretli && bolen_i[VERI_BIT-1]) begin
      mutlak_b = ~bolen_i + BIR;
    end else begin
      mutlak_b = bolen_i;
    end
    if (sifir_bolen) begin
      ozel_sonuc = kalan_islem(islem_i) ? bolunen_i : TUM_BIR;
    end else if (tasma) begin
      ozel_sonuc = kalan_islem(islem_i) ? SIFIR : EN_KUCUK;
    end else begin
      ozel_sonuc = SIFIR;
    end
  end

  // Final-step result: pick quotient or remainder and restore its sign
  always_comb begin
    secilen = kalan_islem(islem) ? kalan_n : bolum_n;
    negatif = isaretli_islem(islem) && (kalan_islem(islem) ? kalan_isaret : bolum_isaret);
    if (negatif) begin
      son_deger = ~secilen + BIR;
    end else begin
      son_deger = secilen;
    end
  end

  // Ready seen by the pipeline; held high through reset so no stall leaks out
  always_comb begin
    if (rst_i) begin
      hazir_o = 1'b1;
    end else begin
      case (durum)
        BOSTA:   hazir_o = ~basla_i;
        HESAPLA: hazir_o = 1'b0;
        BITTI:   hazir_o = 1'b1;
        default: hazir_o = 1'b1;
      endcase
    end
  end

  // Divider FSM; flush outranks everything but reset and leaves sonuc_o alone
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum        <= BOSTA;
      sayac        <= {SW{1'b0}};
      islem        <= 2'b00;
      kalan        <= SIFIR;
      bolum        <= SIFIR;
      bolen        <= SIFIR;
      bolum_isaret <= 1'b0;
      kalan_isaret <= 1'b0;
      sonuc_o      <= SIFIR;
    end else if (iptal_i) begin
      durum <= BOSTA;
      sayac <= {SW{1'b0}};
    end else begin
      case (durum)
        BOSTA: begin
          if (basla_i) begin
            islem        <= islem_i;
            bolum_isaret <= bolunen_i[VERI_BIT-1] ^ bolen_i[VERI_BIT-1];
            kalan_isaret <= bolunen_i[VERI_BIT-1];
            if (sifir_bolen || tasma) begin
              sonuc_o <= ozel_sonuc;
              durum   <= BITTI;
            end else begin
              bolum <= mutlak_a;
              bolen <= mutlak_b;
              kalan <= SIFIR;
              sayac <= SAYAC_SON;
              durum <= HESAPLA;
            end
          end
        end
        HESAPLA: begin
          kalan <= kalan_n;
          bolum <= bolum_n;
          if (sayac == {SW{1'b0}}) begin
            sonuc_o <= son_deger;
            durum   <= BITTI;
          end else begin
            sayac <= sayac - SAYAC_BIR;
          end
        end
        BITTI: begin
          if (!durdur_i) begin
            durum <= BOSTA;
          end
        end
        default: durum <= BOSTA;
      endcase
    end
  end

endmodule

// File: tb/tb_bolme_birimi.sv
// Scoreboard bench for bolme_birimi: stimulus pushes reference results, a
// negedge monitor pops them whenever hazir_o rises after a busy period.
`timescale 1ns/1ps
module tb_bolme_birimi;
  import bolme_birimi_pkg::*;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         basla_i;
  logic [1:0]   islem_i;
  logic [W-1:0] bolunen_i;
  logic [W-1:0] bolen_i;
  logic         durdur_i;
  logic         iptal_i;
  logic         hazir_o;
  logic [W-1:0] sonuc_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] sonuc;
    int           gecikme;
  } beklenen_t;

  beklenen_t    kuyruk[$];
  logic [W-1:0] son_sonuc;

  always #5 clk_i = ~clk_i;

  bolme_birimi #(.VERI_BIT(W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .basla_i   (basla_i),
    .islem_i   (islem_i),
    .bolunen_i (bolunen_i),
    .bolen_i   (bolen_i),
    .durdur_i  (durdur_i),
    .iptal_i   (iptal_i),
    .hazir_o   (hazir_o),
    .sonuc_o   (sonuc_o)
  );

  task automatic chk(input string ad, input logic [W-1:0] gercek, input logic [W-1:0] beklenen);
    total++;
    if (gercek !== beklenen) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", ad, gercek, beklenen);
    end
  endtask

  // Reference: RISC-V M-extension semantics with plain integer arithmetic
  function automatic beklenen_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    beklenen_t e;
    longint sa;
    longint sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) begin
      e.sonuc   = (op == BOLME_REM || op == BOLME_REMU) ? a : 32'hFFFF_FFFF;
      e.gecikme = 1;
    end else if ((op == BOLME_DIV || op == BOLME_REM) && sa == -64'sd2147483648 && sb == -64'sd1) begin
      e.sonuc   = (op == BOLME_REM) ? 32'd0 : 32'h8000_0000;
      e.gecikme = 1;
    end else begin
      e.gecikme = W + 1;
      case (op)
        BOLME_DIV:  e.sonuc = 32'(sa / sb);
        BOLME_DIVU: e.sonuc = a / b;
        BOLME_REM:  e.sonuc = 32'(sa % sb);
        default:    e.sonuc = a % b;
      endcase
    end
    return e;
  endfunction

  // Monitor: a rising hazir_o after a busy stretch is a result unless aborted
  initial begin
    int  dusuk;
    bit  iptal_gordu;
    beklenen_t e;
    dusuk = 0;
    iptal_gordu = 1'b0;
    forever begin
      @(negedge clk_i);
      if (hazir_o === 1'b0) begin
        dusuk++;
        if (iptal_i || rst_i) iptal_gordu = 1'b1;
      end else begin
        if (dusuk > 0 && !iptal_gordu && !rst_i && !iptal_i) begin
          if (kuyruk.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: actual=%h required=no result pending", sonuc_o);
          end else begin
            e = kuyruk.pop_front();
            chk("sonuc", sonuc_o, e.sonuc);
            chk("gecikme", 32'(dusuk), 32'(e.gecikme));
          end
        end
        dusuk = 0;
        iptal_gordu = 1'b0;
      end
    end
  end

  task automatic bekle_hazir();
    int n;
    n = 0;
    @(negedge clk_i);
    while (hazir_o !== 1'b1) begin
      n++;
      if (n > 100) begin
        total++;
        bad++;
        $display("FAIL hazir_timeout: actual=hazir_o 0 for 100 cycles required=hazir_o 1");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "divider never became ready");
      end
      @(negedge clk_i);
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 back in BOSTA
  // with basla_i still high so the caller may start a back-to-back divide.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
    beklenen_t e;
    logic [W-1:0] tutulan;
    e = model(op, a, b);
    kuyruk.push_back(e);
    son_sonuc = e.sonuc;
    islem_i   = op;
    bolunen_i = a;
    bolen_i   = b;
    basla_i   = 1'b1;
    @(posedge clk_i); #1;
    islem_i   = 2'($urandom);
    bolunen_i = $urandom;
    bolen_i   = $urandom;
    bekle_hazir();
    if (stall > 0) begin
      durdur_i = 1'b1;
      tutulan  = sonuc_o;
      repeat (stall) begin
        @(posedge clk_i); #1;
        chk("durdur_hazir", 32'(hazir_o), 32'd1);
        chk("durdur_sonuc", sonuc_o, tutulan);
      end
      durdur_i = 1'b0;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic bosta(input int n);
    basla_i = 1'b0;
    repeat (n) begin
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    int           n;

    rst_i = 1'b1; basla_i = 1'b1; durdur_i = 1'b0; iptal_i = 1'b0;
    islem_i = 2'b00; bolunen_i = 32'd0; bolen_i = 32'd0; son_sonuc = 32'd0;
    #2;
    chk("reset_hazir", 32'(hazir_o), 32'd1);
    chk("reset_sonuc", sonuc_o, 32'd0);
    @(posedge clk_i); #1;
    basla_i = 1'b0;
    rst_i   = 1'b0;
    @(posedge clk_i); #1;

    // Directed cases: basic, signed, divide by zero, overflow
    run_op(BOLME_DIVU, 32'd100, 32'd7, 0);
    run_op(BOLME_REMU, 32'd100, 32'd7, 0);
    run_op(BOLME_DIV,  32'hFFFF_FFF9, 32'd2, 0);
    run_op(BOLME_REM,  32'hFFFF_FFF9, 32'd2, 0);
    run_op(BOLME_DIV,  32'd7, 32'hFFFF_FFFE, 0);
    run_op(BOLME_REM,  32'd7, 32'hFFFF_FFFE, 0);
    run_op(BOLME_DIVU, 32'd5, 32'd0, 0);
    run_op(BOLME_REMU, 32'd5, 32'd0, 0);
    run_op(BOLME_DIV,  32'hFFFF_FFFB, 32'd0, 0);
    run_op(BOLME_REM,  32'hFFFF_FFFB, 32'd0, 0);
    run_op(BOLME_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(BOLME_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    bosta(2);

    // Stall in BITTI, then an immediate back-to-back divide
    run_op(BOLME_DIVU, 32'd1000, 32'd10, 3);
    chk("arka_arkaya_hazir", 32'(hazir_o), 32'd0);
    run_op(BOLME_DIVU, 32'd9, 32'd3, 0);
    bosta(1);

    // Flush in the tenth HESAPLA cycle
    islem_i = BOLME_DIVU; bolunen_i = 32'd12345; bolen_i = 32'd17; basla_i = 1'b1;
    @(posedge clk_i); #1;
    repeat (9) begin
      @(posedge clk_i); #1;
    end
    iptal_i = 1'b1; basla_i = 1'b0;
    @(posedge clk_i); #1;
    iptal_i = 1'b0;
    chk("iptal_hazir", 32'(hazir_o), 32'd1);
    chk("iptal_sonuc", sonuc_o, son_sonuc);
    bosta(35);
    chk("iptal_sonra_sonuc", sonuc_o, son_sonuc);

    // Flush in BOSTA suppresses a would-be one-cycle divide by zero
    islem_i = BOLME_DIVU; bolunen_i = 32'd5; bolen_i = 32'd0; basla_i = 1'b1; iptal_i = 1'b1;
    #1;
    chk("iptal_bosta_hazir", 32'(hazir_o), 32'd0);
    @(posedge clk_i); #1;
    basla_i = 1'b0; iptal_i = 1'b0;
    bosta(3);
    chk("iptal_bosta_sonuc", sonuc_o, son_sonuc);
    chk("iptal_bosta_hazir1", 32'(hazir_o), 32'd1);

    // Reset in the middle of HESAPLA
    islem_i = BOLME_DIV; bolunen_i = 32'h1234_5678; bolen_i = 32'd3; basla_i = 1'b1;
    repeat (6) begin
      @(posedge clk_i); #1;
    end
    rst_i = 1'b1;
    #1;
    chk("rst_orta_hazir", 32'(hazir_o), 32'd1);
    chk("rst_orta_sonuc", sonuc_o, 32'd0);
    basla_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    son_sonuc = 32'd0;
    bosta(1);

    // Randomized traffic with stalls and idle gaps
    for (int i = 0; i < 40; i++) begin
      n  = int'($urandom_range(0, 9));
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      if (n == 0) b = 32'd0;
      else if (n == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (n <= 4) b = 32'($urandom_range(1, 300));
      if (n == 5) a = 32'($urandom_range(0, 1000));
      run_op(op, a, b, int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 0) bosta(int'($urandom_range(1, 3)));
    end
    bosta(3);

    chk("kuyruk_bos", 32'(kuyruk.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
